vga_framebuffer_reader: RTL and testbench

//  Downstream stage of the VGA timing controller. Consumes its valid/h_sync/v_sync stream and

---
 rtl/vga_framebuffer_reader_if.sv | 12 +
 rtl/vga_framebuffer_reader.sv | 138 +++++++++++++
 tb/tb_vga_framebuffer_reader.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_framebuffer_reader_if.sv
// Framebuffer read port: the VGA reader drives address/strobe, the pixel RAM returns data.
interface vga_framebuffer_reader_if #(
  parameter int ADDR_WIDTH  = 17,
  parameter int PIXEL_WIDTH = 12
);
  logic [ADDR_WIDTH-1:0]  mem_addr;
  logic                   mem_rd_en;
  logic [PIXEL_WIDTH-1:0] mem_rd_data;

  modport master (output mem_addr, output mem_rd_en, input mem_rd_data);
  modport slave  (input mem_addr, input mem_rd_en, output mem_rd_data);
endinterface

// File: rtl/vga_framebuffer_reader.sv
// VGA framebuffer reader: turns the timing controller's valid/sync stream into upscaled
// framebuffer read addresses, hides the RAM read latency by delaying valid/enable/syncs,
// and drives pixel plus syncs to the DAC with a fixed PIPE-cycle latency.
module vga_framebuffer_reader #(
  parameter int H_VISIBLE_AREA = 640,
  parameter int V_VISIBLE_AREA = 480,
  parameter int SCALE_SHIFT    = 1,
  parameter int MEM_LATENCY    = 2,
  parameter int PIXEL_WIDTH    = 12,
  parameter logic [PIXEL_WIDTH-1:0] BLANK_COLOR = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic                       in_valid,
  input  logic                       in_h_sync,
  input  logic                       in_v_sync,
  vga_framebuffer_reader_if.master   mem,
  output logic [PIXEL_WIDTH-1:0]     pixel,
  output logic                       h_sync,
  output logic                       v_sync,
  output logic                       frame_done
);

  localparam int FB_W       = H_VISIBLE_AREA >> SCALE_SHIFT;
  localparam int FB_H       = V_VISIBLE_AREA >> SCALE_SHIFT;
  localparam int ADDR_WIDTH = $clog2(FB_W * FB_H);
  localparam int PIPE       = MEM_LATENCY + 2;
  // valid/enable need one stage less than the syncs: the pixel register supplies the last one
  localparam int DLY        = PIPE - 1;
  localparam int X_WIDTH    = (H_VISIBLE_AREA > 1) ? $clog2(H_VISIBLE_AREA) : 1;
  localparam int Y_WIDTH    = (V_VISIBLE_AREA > 1) ? $clog2(V_VISIBLE_AREA) : 1;

  logic [X_WIDTH-1:0]     x_q, x_d;
  logic [Y_WIDTH-1:0]     y_q, y_d;
  logic [ADDR_WIDTH-1:0]  line_base_q, line_base_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic                   rd_en_q, rd_en_d;
  logic                   frame_done_q, frame_done_d;
  logic                   valid_prev_q, valid_prev_d;
  logic                   vsync_prev_q, vsync_prev_d;
  logic [DLY-1:0]         dv_q, dv_d;
  logic [DLY-1:0]         en_dly_q, en_dly_d;
  logic [PIPE-1:0]        hs_pipe_q, hs_pipe_d;
  logic [PIPE-1:0]        vs_pipe_q, vs_pipe_d;
  logic [PIXEL_WIDTH-1:0] pixel_q, pixel_d;
  logic                   line_end;
  logic                   resync;

  assign line_end = valid_prev_q && !in_valid;
  assign resync   = vsync_prev_q && !in_v_sync;

  // Address generation: row base advances incrementally every 2**SCALE_SHIFT lines; v_sync resyncs.
  always_comb begin
    x_d          = x_q;
    y_d          = y_q;
    line_base_d  = line_base_q;
    addr_d       = addr_q;
    rd_en_d      = 1'b0;
    frame_done_d = 1'b0;
    valid_prev_d = in_valid;
    vsync_prev_d = in_v_sync;
    if (in_valid) begin
      addr_d  = line_base_q + ADDR_WIDTH'(x_q >> SCALE_SHIFT);
      rd_en_d = 1'b1;
      if (x_q != X_WIDTH'(H_VISIBLE_AREA - 1)) begin
        x_d = x_q + 1'b1;
      end
    end
    if (resync) begin
      x_d         = '0;
      y_d         = '0;
      line_base_d = '0;
    end else if (line_end) begin
      x_d = '0;
      if (y_q == Y_WIDTH'(V_VISIBLE_AREA - 1)) begin
        y_d          = '0;
        line_base_d  = '0;
        frame_done_d = 1'b1;
      end else begin
        y_d = y_q + 1'b1;
        if (((y_d >> SCALE_SHIFT) << SCALE_SHIFT) == y_d) begin
          line_base_d = line_base_q + ADDR_WIDTH'(FB_W);
        end
      end
    end
  end

  // Latency compensation: valid/enable/syncs delayed so they line up with returning RAM data.
  always_comb begin
    dv_d      = {dv_q[DLY-2:0], in_valid};
    en_dly_d  = {en_dly_q[DLY-2:0], enable};
    hs_pipe_d = {hs_pipe_q[PIPE-2:0], in_h_sync};
    vs_pipe_d = {vs_pipe_q[PIPE-2:0], in_v_sync};
    pixel_d   = (dv_q[DLY-1] && en_dly_q[DLY-1]) ? mem.mem_rd_data : BLANK_COLOR;
  end

  // State registers with synchronous reset flushing the whole pipeline.
  always_ff @(posedge clk) begin
    if (reset) begin
      x_q          <= '0;
      y_q          <= '0;
      line_base_q  <= '0;
      addr_q       <= '0;
      rd_en_q      <= 1'b0;
      frame_done_q <= 1'b0;
      valid_prev_q <= 1'b0;
      vsync_prev_q <= 1'b0;
      dv_q         <= '0;
      en_dly_q     <= '0;
      hs_pipe_q    <= '0;
      vs_pipe_q    <= '0;
      pixel_q      <= '0;
    end else begin
      x_q          <= x_d;
      y_q          <= y_d;
      line_base_q  <= line_base_d;
      addr_q       <= addr_d;
      rd_en_q      <= rd_en_d;
      frame_done_q <= frame_done_d;
      valid_prev_q <= valid_prev_d;
      vsync_prev_q <= vsync_prev_d;
      dv_q         <= dv_d;
      en_dly_q     <= en_dly_d;
      hs_pipe_q    <= hs_pipe_d;
      vs_pipe_q    <= vs_pipe_d;
      pixel_q      <= pixel_d;
    end
  end

  assign mem.mem_addr  = addr_q;
  assign mem.mem_rd_en = rd_en_q;
  assign pixel         = pixel_q;
  assign h_sync        = hs_pipe_q[PIPE-1];
  assign v_sync        = vs_pipe_q[PIPE-1];
  assign frame_done    = frame_done_q;

endmodule

// File: tb/tb_vga_framebuffer_reader.sv
// Testbench for vga_framebuffer_reader: small 8x4 raster, 2x upscale, RAM returning its address.
module tb_vga_framebuffer_reader;
  localparam int H    = 8;
  localparam int V    = 4;
  localparam int S    = 1;
  localparam int ML   = 2;
  localparam int PW   = 12;
  localparam int FBW  = H >> S;
  localparam int AW   = $clog2(FBW * (V >> S));
  localparam int PIPE = ML + 2;

  typedef struct packed {
    logic v;
    logic hs;
    logic vs;
    logic en;
    logic rst;
  } stim_t;

  logic          clk;
  logic          reset;
  logic          enable;
  logic          in_valid;
  logic          in_h_sync;
  logic          in_v_sync;
  logic [PW-1:0] pixel;
  logic          h_sync;
  logic          v_sync;
  logic          frame_done;
  logic [AW-1:0] ram_q1;
  logic [AW-1:0] ram_q2;

  vga_framebuffer_reader_if #(.ADDR_WIDTH(AW), .PIXEL_WIDTH(PW)) mem_if ();

  vga_framebuffer_reader #(
    .H_VISIBLE_AREA(H), .V_VISIBLE_AREA(V), .SCALE_SHIFT(S),
    .MEM_LATENCY(ML), .PIXEL_WIDTH(PW), .BLANK_COLOR('0)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .in_valid(in_valid),
    .in_h_sync(in_h_sync), .in_v_sync(in_v_sync), .mem(mem_if),
    .pixel(pixel), .h_sync(h_sync), .v_sync(v_sync), .frame_done(frame_done)
  );

  // Pixel clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Framebuffer RAM model: two-cycle read latency, content equals address.
  always @(posedge clk) begin
    ram_q1 <= mem_if.mem_addr;
    ram_q2 <= ram_q1;
  end
  assign mem_if.mem_rd_data = PW'(ram_q2);

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  stim_t sq[$];

  int mx, my;
  bit pv, pvs;
  logic [AW-1:0] exp_addr;
  bit exp_rd, exp_fd;
  logic [PW-1:0] ring_pix[8];
  bit ring_hs[8];
  bit ring_vs[8];

  task automatic push(input bit v, input bit hs, input bit vs, input bit en, input bit rst);
    stim_t s;
    s.v = v; s.hs = hs; s.vs = vs; s.en = en; s.rst = rst;
    sq.push_back(s);
  endtask

  task automatic push_line(input int nvis, input bit vs, input bit rand_en);
    int fp, bp;
    fp = 1 + int'($urandom_range(0, 1));
    bp = 1 + int'($urandom_range(0, 2));
    for (int i = 0; i < nvis; i++) push(1'b1, 1'b1, vs, rand_en ? bit'($urandom_range(0, 1)) : 1'b1, 1'b0);
    for (int i = 0; i < fp; i++) push(1'b0, 1'b1, vs, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) push(1'b0, 1'b0, vs, 1'b1, 1'b0);
    for (int i = 0; i < bp; i++) push(1'b0, 1'b1, vs, 1'b1, 1'b0);
  endtask

  task automatic push_vblank();
    push_line(0, 1'b1, 1'b0);
    push_line(0, 1'b0, 1'b0);
    push_line(0, 1'b1, 1'b0);
  endtask

  task automatic push_frame(input bit rand_en);
    for (int l = 0; l < V; l++) push_line(H, 1'b1, rand_en);
    push_vblank();
  endtask

  // Drive one cycle and advance the reference model: the address is the source pixel
  // (row y/2, column min(x,H-1)/2) in a row-major 4-wide framebuffer; outputs lag by PIPE.
  task automatic step(input stim_t s);
    bit line_end, resync;
    reset = s.rst; in_valid = s.v; in_h_sync = s.hs; in_v_sync = s.vs; enable = s.en;
    if (s.rst) begin
      mx = 0; my = 0; pv = 0; pvs = 0;
      exp_addr = '0; exp_rd = 0; exp_fd = 0;
      for (int k = 0; k < PIPE; k++) begin
        ring_pix[(cyc - k) & 7] = '0;
        ring_hs[(cyc - k) & 7] = 0;
        ring_vs[(cyc - k) & 7] = 0;
      end
    end else begin
      exp_rd = s.v;
      exp_fd = 0;
      if (s.v) begin
        exp_addr = AW'((my >> S) * FBW + (((mx < H) ? mx : H - 1) >> S));
        mx++;
      end
      line_end = pv && !s.v;
      resync = pvs && !s.vs;
      if (resync) begin
        mx = 0; my = 0;
      end else if (line_end) begin
        mx = 0;
        if (my == V - 1) begin
          my = 0; exp_fd = 1;
        end else begin
          my++;
        end
      end
      pv = s.v; pvs = s.vs;
      ring_pix[cyc & 7] = (s.v && s.en) ? PW'(exp_addr) : '0;
      ring_hs[cyc & 7] = s.hs;
      ring_vs[cyc & 7] = s.vs;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    stim_t s;
    sq.delete();
    for (int i = 0; i < 3; i++) push(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), 1'b1, 1'b1, 1'b1);
    while (sq.size() > 0) begin
      s = sq.pop_front();
      step(s);
      checks++; if (mem_if.mem_addr !== '0) begin errors++; $display("[TB] FAIL reset_addr got %0d exp 0", mem_if.mem_addr); end
      checks++; if (mem_if.mem_rd_en !== 1'b0) begin errors++; $display("[TB] FAIL reset_rd_en got %b exp 0", mem_if.mem_rd_en); end
      checks++; if (pixel !== '0) begin errors++; $display("[TB] FAIL reset_pixel got %0h exp 0", pixel); end
      checks++; if (h_sync !== 1'b0) begin errors++; $display("[TB] FAIL reset_h_sync got %b exp 0", h_sync); end
      checks++; if (v_sync !== 1'b0) begin errors++; $display("[TB] FAIL reset_v_sync got %b exp 0", v_sync); end
      checks++; if (frame_done !== 1'b0) begin errors++; $display("[TB] FAIL reset_frame_done got %b exp 0", frame_done); end
    end
    for (int i = 0; i < 6; i++) push(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    while (sq.size() > 0) begin s = sq.pop_front(); step(s); end
  endtask

  task automatic test_full_frame();
    stim_t s;
    int fd_count = 0;
    logic [AW-1:0] seen[$];
    int golden[32] = '{0,0,1,1,2,2,3,3, 0,0,1,1,2,2,3,3, 4,4,5,5,6,6,7,7, 4,4,5,5,6,6,7,7};
    sq.delete();
    push_frame(1'b0);
    push_frame(1'b0);
    while (sq.size() > 0) begin
      s = sq.pop_front();
      step(s);
      checks++; if (mem_if.mem_addr !== exp_addr) begin errors++; $display("[TB] FAIL frame_addr cyc=%0d got %0d exp %0d", cyc, mem_if.mem_addr, exp_addr); end
      checks++; if (mem_if.mem_rd_en !== exp_rd) begin errors++; $display("[TB] FAIL frame_rd_en cyc=%0d got %b exp %b", cyc, mem_if.mem_rd_en, exp_rd); end
      checks++; if (frame_done !== exp_fd) begin errors++; $display("[TB] FAIL frame_done cyc=%0d got %b exp %b", cyc, frame_done, exp_fd); end
      if (frame_done === 1'b1) fd_count++;
      if (s.v && seen.size() < 32) seen.push_back(mem_if.mem_addr);
    end
    checks++; if (fd_count !== 2) begin errors++; $display("[TB] FAIL frame_done_count got %0d exp 2", fd_count); end
    checks++; if (seen.size() !== 32) begin errors++; $display("[TB] FAIL frame_addr_count got %0d exp 32", seen.size()); end
    for (int i = 0; i < 32 && i < seen.size(); i++) begin
      checks++; if (seen[i] !== AW'(golden[i])) begin errors++; $display("[TB] FAIL frame_table idx=%0d got %0d exp %0d", i, seen[i], golden[i]); end
    end
  endtask

  task automatic test_latency();
    stim_t s;
    int t_in = -1;
    int t_out = -1;
    logic prev_hs = 1'b1;
    sq.delete();
    for (int i = 0; i < 6; i++) push(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    push_frame(1'b0);
    while (sq.size() > 0) begin
      s = sq.pop_front();
      if (t_in < 0 && s.hs == 1'b0) t_in = cyc;
      step(s);
      checks++; if (pixel !== ring_pix[(cyc - PIPE) & 7]) begin errors++; $display("[TB] FAIL lat_pixel cyc=%0d got %0h exp %0h", cyc, pixel, ring_pix[(cyc - PIPE) & 7]); end
      checks++; if (h_sync !== ring_hs[(cyc - PIPE) & 7]) begin errors++; $display("[TB] FAIL lat_h_sync cyc=%0d got %b exp %b", cyc, h_sync, ring_hs[(cyc - PIPE) & 7]); end
      checks++; if (v_sync !== ring_vs[(cyc - PIPE) & 7]) begin errors++; $display("[TB] FAIL lat_v_sync cyc=%0d got %b exp %b", cyc, v_sync, ring_vs[(cyc - PIPE) & 7]); end
      if (t_in >= 0 && t_out < 0 && prev_hs === 1'b1 && h_sync === 1'b0) t_out = cyc;
      prev_hs = h_sync;
    end
    checks++; if ((t_out - t_in) !== PIPE) begin errors++; $display("[TB] FAIL lat_h_sync_delay got %0d exp %0d", t_out - t_in, PIPE); end
  endtask

  task automatic test_blanking();
    stim_t s;
    sq.delete();
    push_frame(1'b1);
    while (sq.size() > 0) begin
      s = sq.pop_front();
      step(s);
      checks++; if (pixel !== ring_pix[(cyc - PIPE) & 7]) begin errors++; $display("[TB] FAIL blank_pixel cyc=%0d got %0h exp %0h", cyc, pixel, ring_pix[(cyc - PIPE) & 7]); end
      checks++; if (mem_if.mem_addr !== exp_addr) begin errors++; $display("[TB] FAIL blank_addr cyc=%0d got %0d exp %0d", cyc, mem_if.mem_addr, exp_addr); end
    end
  endtask

  task automatic test_resync();
    stim_t s;
    int fd_count = 0;
    bit after_vs = 0;
    bit first_done = 0;
    sq.delete();
    push_line(H, 1'b1, 1'b0);
    push_line(H, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) push(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) push(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    push_line(0, 1'b0, 1'b0);
    push_line(0, 1'b1, 1'b0);
    push_frame(1'b0);
    while (sq.size() > 0) begin
      s = sq.pop_front();
      if (s.vs == 1'b0) after_vs = 1;
      step(s);
      checks++; if (mem_if.mem_addr !== exp_addr) begin errors++; $display("[TB] FAIL resync_addr cyc=%0d got %0d exp %0d", cyc, mem_if.mem_addr, exp_addr); end
      checks++; if (frame_done !== exp_fd) begin errors++; $display("[TB] FAIL resync_frame_done cyc=%0d got %b exp %b", cyc, frame_done, exp_fd); end
      if (frame_done === 1'b1) fd_count++;
      if (after_vs && s.v && !first_done) begin
        first_done = 1;
        checks++; if (mem_if.mem_addr !== '0) begin errors++; $display("[TB] FAIL resync_first_addr got %0d exp 0", mem_if.mem_addr); end
      end
    end
    checks++; if (fd_count !== 1) begin errors++; $display("[TB] FAIL resync_frame_done_count got %0d exp 1", fd_count); end
  endtask

  task automatic test_mid_reset();
    stim_t s;
    sq.delete();
    push_line(H, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) push(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    push(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) push(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    push_line(0, 1'b1, 1'b0);
    push_line(H, 1'b1, 1'b0);
    push_line(H, 1'b1, 1'b0);
    push_vblank();
    push_frame(1'b0);
    while (sq.size() > 0) begin
      s = sq.pop_front();
      step(s);
      checks++; if (mem_if.mem_addr !== exp_addr) begin errors++; $display("[TB] FAIL mrst_addr cyc=%0d got %0d exp %0d", cyc, mem_if.mem_addr, exp_addr); end
      checks++; if (mem_if.mem_rd_en !== exp_rd) begin errors++; $display("[TB] FAIL mrst_rd_en cyc=%0d got %b exp %b", cyc, mem_if.mem_rd_en, exp_rd); end
      checks++; if (pixel !== ring_pix[(cyc - PIPE) & 7]) begin errors++; $display("[TB] FAIL mrst_pixel cyc=%0d got %0h exp %0h", cyc, pixel, ring_pix[(cyc - PIPE) & 7]); end
      checks++; if (h_sync !== ring_hs[(cyc - PIPE) & 7]) begin errors++; $display("[TB] FAIL mrst_h_sync cyc=%0d got %b exp %b", cyc, h_sync, ring_hs[(cyc - PIPE) & 7]); end
      checks++; if (v_sync !== ring_vs[(cyc - PIPE) & 7]) begin errors++; $display("[TB] FAIL mrst_v_sync cyc=%0d got %b exp %b", cyc, v_sync, ring_vs[(cyc - PIPE) & 7]); end
      checks++; if (frame_done !== exp_fd) begin errors++; $display("[TB] FAIL mrst_frame_done cyc=%0d got %b exp %b", cyc, frame_done, exp_fd); end
    end
  endtask

  task automatic test_overlong();
    stim_t s;
    int n_valid = 0;
    logic [AW-1:0] max_addr = '0;
    sq.delete();
    push_line(10, 1'b1, 1'b0);
    for (int l = 1; l < V; l++) push_line(H, 1'b1, 1'b0);
    push_vblank();
    while (sq.size() > 0) begin
      s = sq.pop_front();
      step(s);
      checks++; if (mem_if.mem_addr !== exp_addr) begin errors++; $display("[TB] FAIL long_addr cyc=%0d got %0d exp %0d", cyc, mem_if.mem_addr, exp_addr); end
      checks++; if (mem_if.mem_rd_en !== exp_rd) begin errors++; $display("[TB] FAIL long_rd_en cyc=%0d got %b exp %b", cyc, mem_if.mem_rd_en, exp_rd); end
      if (s.v && n_valid < 10) begin
        n_valid++;
        if (mem_if.mem_addr > max_addr) max_addr = mem_if.mem_addr;
      end
    end
    checks++; if (max_addr !== AW'(3)) begin errors++; $display("[TB] FAIL long_max_addr got %0d exp 3", max_addr); end
  endtask

  // Safety net so the bench always terminates.
  initial begin
    #500000;
    $display("[TB] FAIL timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "[TB] timeout");
  end

  // Test sequence.
  initial begin
    reset = 1'b1; enable = 1'b1; in_valid = 1'b0; in_h_sync = 1'b1; in_v_sync = 1'b1;
    test_reset();
    test_full_frame();
    test_latency();
    test_blanking();
    test_resync();
    test_mid_reset();
    test_overlong();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
